// File: rtl/vt52_pkg.sv
// Shared VT52 definitions: escape byte, keyboard key codes, identify reply
// bytes and the key-encoder FSM state type.
package vt52_pkg;

    localparam logic [7:0] ESC          = 8'h1B;

    // Cursor and function keys
    localparam logic [7:0] KEY_UP       = 8'h80;
    localparam logic [7:0] KEY_DOWN     = 8'h81;
    localparam logic [7:0] KEY_RIGHT    = 8'h82;
    localparam logic [7:0] KEY_LEFT     = 8'h83;
    localparam logic [7:0] KEY_BLUE     = 8'h84;
    localparam logic [7:0] KEY_RED      = 8'h85;
    localparam logic [7:0] KEY_GRAY     = 8'h86;

    // Keypad keys
    localparam logic [7:0] KEY_KP_0     = 8'h90;
    localparam logic [7:0] KEY_KP_9     = 8'h99;
    localparam logic [7:0] KEY_KP_DOT   = 8'h9A;
    localparam logic [7:0] KEY_KP_ENTER = 8'h9B;

    // Identify reply is ESC / K
    localparam logic [7:0] IDENT_MID    = 8'h2F;
    localparam logic [7:0] IDENT_FIN    = 8'h4B;

    // Alternate-keypad prefix byte after ESC
    localparam logic [7:0] ALT_PREFIX   = 8'h3F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ESC,
        ST_MID,
        ST_FINAL
    } key_state_e;

endpackage

// File: rtl/sync_signal.sv
// Multi-flop synchroniser for asynchronous level inputs.
module sync_signal #(
    parameter int WIDTH = 1,
    parameter int N     = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_reg [N];

    // First stage samples the asynchronous input
    always_ff @(posedge clk) begin
        if (!rstn) begin
            stage_reg[0] <= '0;
        end else begin
            stage_reg[0] <= d;
        end
    end

    generate
        for (genvar gi = 1; gi < N; gi++) begin : g_stage
            // Each further stage re-registers the previous one
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    stage_reg[gi] <= '0;
                end else begin
                    stage_reg[gi] <= stage_reg[gi-1];
                end
            end
        end
    endgenerate

    assign q = stage_reg[N-1];

endmodule

// File: rtl/vt52_key_fifo.sv
// Small synchronous key-code FIFO. The head entry is visible on rd_data
// without a read request so the encoder can decode it in the pop cycle.
module vt52_key_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             wr_ok;
    logic             rd_ok;

    // Full is judged on the current count, so a same-cycle read never makes room
    assign full    = (count_reg == DEPTH_C);
    assign empty   = (count_reg == '0);
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign rd_data = mem_reg[rd_ptr_reg];

    // Storage array; contents need no reset since count guards every read
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_reg[wr_ptr_reg] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/vt52_key_encoder.sv
// VT52 keyboard encoder: queues key presses, maps each to its host byte
// sequence and streams the bytes out over AXI-stream. Identify requests
// are answered with ESC / K ahead of queued keys.
module vt52_key_encoder
    import vt52_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] key_code,
    input  logic       key_strobe,
    input  logic       alt_keypad,
    input  logic       ident_req,
    output logic [7:0] m_tdata,
    output logic       m_tvalid,
    input  logic       m_tready,
    output logic       overflow,
    output logic       busy
);

    key_state_e state_reg;
    logic [7:0] m_tdata_reg;
    logic       m_tvalid_reg;
    logic       overflow_reg;
    logic       ident_pending_reg;
    logic       seq_long_reg;
    logic [7:0] seq_mid_reg;
    logic [7:0] seq_fin_reg;
    logic       sync_prev_reg;
    logic       edge_reg;

    logic       strobe_sync;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_rd;
    logic [7:0] fifo_head;
    logic       work_avail;
    logic       ident_serve;

    logic [1:0] dec_len;
    logic [7:0] dec_mid;
    logic [7:0] dec_fin;

    sync_signal #(
        .WIDTH (1),
        .N     (SYNC_STAGES)
    ) u_strobe_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (key_strobe),
        .q    (strobe_sync)
    );

    vt52_key_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (edge_reg),
        .wr_data (key_code),
        .rd_en   (fifo_rd),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign work_avail  = ident_pending_reg || !fifo_empty;
    assign ident_serve = (state_reg == ST_LOAD) && ident_pending_reg;
    assign fifo_rd     = (state_reg == ST_LOAD) && !ident_pending_reg;

    assign m_tdata  = m_tdata_reg;
    assign m_tvalid = m_tvalid_reg;
    assign overflow = overflow_reg;
    assign busy     = (state_reg != ST_IDLE) || !fifo_empty;

    // Registered rising-edge detect on the synchronised strobe, plus drop reporting
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync_prev_reg <= 1'b0;
            edge_reg      <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            sync_prev_reg <= strobe_sync;
            edge_reg      <= strobe_sync && !sync_prev_reg;
            overflow_reg  <= edge_reg && fifo_full;
        end
    end

    // Map the queue head to its byte sequence; len 0 marks an unmapped code
    always_comb begin
        dec_len = 2'd0;
        dec_mid = 8'h00;
        dec_fin = 8'h00;
        if (!fifo_head[7]) begin
            dec_len = 2'd1;
            dec_fin = fifo_head;
        end else begin
            case (fifo_head)
                KEY_UP:    begin dec_len = 2'd2; dec_fin = 8'h41; end
                KEY_DOWN:  begin dec_len = 2'd2; dec_fin = 8'h42; end
                KEY_RIGHT: begin dec_len = 2'd2; dec_fin = 8'h43; end
                KEY_LEFT:  begin dec_len = 2'd2; dec_fin = 8'h44; end
                KEY_BLUE:  begin dec_len = 2'd2; dec_fin = 8'h50; end
                KEY_RED:   begin dec_len = 2'd2; dec_fin = 8'h51; end
                KEY_GRAY:  begin dec_len = 2'd2; dec_fin = 8'h52; end
                KEY_KP_DOT: begin
                    if (alt_keypad) begin
                        dec_len = 2'd3; dec_mid = ALT_PREFIX; dec_fin = 8'h6E;
                    end else begin
                        dec_len = 2'd1; dec_fin = 8'h2E;
                    end
                end
                KEY_KP_ENTER: begin
                    if (alt_keypad) begin
                        dec_len = 2'd3; dec_mid = ALT_PREFIX; dec_fin = 8'h4D;
                    end else begin
                        dec_len = 2'd1; dec_fin = 8'h0D;
                    end
                end
                default: begin
                    if (fifo_head >= KEY_KP_0 && fifo_head <= KEY_KP_9) begin
                        if (alt_keypad) begin
                            dec_len = 2'd3;
                            dec_mid = ALT_PREFIX;
                            dec_fin = 8'h70 + {4'h0, fifo_head[3:0]};
                        end else begin
                            dec_len = 2'd1;
                            dec_fin = 8'h30 + {4'h0, fifo_head[3:0]};
                        end
                    end
                end
            endcase
        end
    end

    // Sequencer: loads one sequence at a time and walks its bytes through the handshake
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg         <= ST_IDLE;
            m_tdata_reg       <= 8'h00;
            m_tvalid_reg      <= 1'b0;
            ident_pending_reg <= 1'b0;
            seq_long_reg      <= 1'b0;
            seq_mid_reg       <= 8'h00;
            seq_fin_reg       <= 8'h00;
        end else begin
            // Pulses arriving while a reply is pending or being loaded merge into it
            ident_pending_reg <= ident_serve ? 1'b0 : (ident_pending_reg | ident_req);
            case (state_reg)
                ST_IDLE: begin
                    if (work_avail) begin
                        state_reg <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (ident_pending_reg) begin
                        m_tdata_reg  <= ESC;
                        m_tvalid_reg <= 1'b1;
                        seq_long_reg <= 1'b1;
                        seq_mid_reg  <= IDENT_MID;
                        seq_fin_reg  <= IDENT_FIN;
                        state_reg    <= ST_ESC;
                    end else begin
                        case (dec_len)
                            2'd1: begin
                                m_tdata_reg  <= dec_fin;
                                m_tvalid_reg <= 1'b1;
                                state_reg    <= ST_FINAL;
                            end
                            2'd2: begin
                                m_tdata_reg  <= ESC;
                                m_tvalid_reg <= 1'b1;
                                seq_long_reg <= 1'b0;
                                seq_fin_reg  <= dec_fin;
                                state_reg    <= ST_ESC;
                            end
                            2'd3: begin
                                m_tdata_reg  <= ESC;
                                m_tvalid_reg <= 1'b1;
                                seq_long_reg <= 1'b1;
                                seq_mid_reg  <= dec_mid;
                                seq_fin_reg  <= dec_fin;
                                state_reg    <= ST_ESC;
                            end
                            default: state_reg <= ST_IDLE;
                        endcase
                    end
                end
                ST_ESC: begin
                    if (m_tready) begin
                        if (seq_long_reg) begin
                            m_tdata_reg <= seq_mid_reg;
                            state_reg   <= ST_MID;
                        end else begin
                            m_tdata_reg <= seq_fin_reg;
                            state_reg   <= ST_FINAL;
                        end
                    end
                end
                ST_MID: begin
                    if (m_tready) begin
                        m_tdata_reg <= seq_fin_reg;
                        state_reg   <= ST_FINAL;
                    end
                end
                ST_FINAL: begin
                    if (m_tready) begin
                        m_tvalid_reg <= 1'b0;
                        state_reg    <= work_avail ? ST_LOAD : ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vt52_key_encoder.sv
// Self-checking bench for vt52_key_encoder: table of single-key mappings
// plus hand-written latency, stall, identify, overflow and reset sequences.
module tb_vt52_key_encoder;

    localparam int SYNC  = 2;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] key_code = 8'h00;
    logic       key_strobe = 1'b0;
    logic       alt_keypad = 1'b0;
    logic       ident_req = 1'b0;
    logic [7:0] m_tdata;
    logic       m_tvalid;
    logic       m_tready = 1'b1;
    logic       overflow;
    logic       busy;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic [7:0] data;
        bit         first;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [7:0] code;
        logic       alt;
        int         n;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
    } vec_t;
    vec_t vecs[18];

    int         cycle = 0;
    int         last_hs = 0;
    bit         ready_dropped = 1'b1;
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic       prev_rstn = 1'b0;
    logic [7:0] prev_data = 8'h00;
    int         ovf_count = 0;

    vt52_key_encoder #(
        .SYNC_STAGES (SYNC),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .key_code   (key_code),
        .key_strobe (key_strobe),
        .alt_keypad (alt_keypad),
        .ident_req  (ident_req),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic push_seq(input int n, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2);
        exp_t e;
        if (n >= 1) begin e.data = b0; e.first = 1'b1; exp_q.push_back(e); end
        if (n >= 2) begin e.data = b1; e.first = 1'b0; exp_q.push_back(e); end
        if (n >= 3) begin e.data = b2; e.first = 1'b0; exp_q.push_back(e); end
    endtask

    task automatic strobe(input logic [7:0] code);
        @(posedge clk); #1;
        key_code   = code;
        key_strobe = 1'b1;
        repeat (SYNC + 2) @(posedge clk);
        #1 key_strobe = 1'b0;
        repeat (SYNC + 1) @(posedge clk);
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit done;
        done = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (!busy && !m_tvalid && exp_q.size() == 0) done = 1'b1;
        end
        if (!done) begin
            checks++;
            $display("FAIL %s: timeout, busy=%0b tvalid=%0b pending=%0d", name, busy, m_tvalid,
                     exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_valid(input string name, input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (m_tvalid) done = 1'b1;
        end
        if (!done) begin
            checks++;
            $display("FAIL %s: timeout waiting for tvalid, got 0, expected 1", name);
        end
    endtask

    // Output monitor and scoreboard, sampled on the falling edge
    always @(negedge clk) begin
        exp_t e;
        cycle++;
        if (overflow) ovf_count++;
        if (prev_valid && !prev_ready && prev_rstn) begin
            check("hold_tvalid", m_tvalid, 1);
            check("hold_tdata", m_tdata, prev_data);
        end
        if (rstn && m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_byte: got %02h, expected no byte (cycle %0d)", m_tdata,
                         cycle);
            end else begin
                e = exp_q.pop_front();
                check("byte", m_tdata, e.data);
                if (!e.first && !ready_dropped) check("no_gap", cycle, last_hs + 1);
                $display("byte %02h at cycle %0d", m_tdata, cycle);
            end
            last_hs = cycle;
            ready_dropped = 1'b0;
        end else if (!m_tready || !rstn) begin
            ready_dropped = 1'b1;
        end
        prev_valid = m_tvalid;
        prev_ready = m_tready;
        prev_rstn  = rstn;
        prev_data  = m_tdata;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;

        vecs[0]  = '{8'h41, 1'b0, 1, 8'h41, 8'h00, 8'h00};
        vecs[1]  = '{8'h80, 1'b0, 2, 8'h1B, 8'h41, 8'h00};
        vecs[2]  = '{8'h9A, 1'b1, 3, 8'h1B, 8'h3F, 8'h6E};
        vecs[3]  = '{8'h9A, 1'b0, 1, 8'h2E, 8'h00, 8'h00};
        vecs[4]  = '{8'h81, 1'b0, 2, 8'h1B, 8'h42, 8'h00};
        vecs[5]  = '{8'h82, 1'b1, 2, 8'h1B, 8'h43, 8'h00};
        vecs[6]  = '{8'h83, 1'b0, 2, 8'h1B, 8'h44, 8'h00};
        vecs[7]  = '{8'h84, 1'b0, 2, 8'h1B, 8'h50, 8'h00};
        vecs[8]  = '{8'h85, 1'b0, 2, 8'h1B, 8'h51, 8'h00};
        vecs[9]  = '{8'h86, 1'b0, 2, 8'h1B, 8'h52, 8'h00};
        vecs[10] = '{8'h90, 1'b0, 1, 8'h30, 8'h00, 8'h00};
        vecs[11] = '{8'h95, 1'b1, 3, 8'h1B, 8'h3F, 8'h75};
        vecs[12] = '{8'h99, 1'b0, 1, 8'h39, 8'h00, 8'h00};
        vecs[13] = '{8'h9B, 1'b1, 3, 8'h1B, 8'h3F, 8'h4D};
        vecs[14] = '{8'h9B, 1'b0, 1, 8'h0D, 8'h00, 8'h00};
        vecs[15] = '{8'h7F, 1'b1, 1, 8'h7F, 8'h00, 8'h00};
        vecs[16] = '{8'hC0, 1'b0, 0, 8'h00, 8'h00, 8'h00};
        vecs[17] = '{8'h87, 1'b0, 0, 8'h00, 8'h00, 8'h00};

        // Reset state
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_tdata", m_tdata, 0);
        check("reset_tvalid", m_tvalid, 0);
        check("reset_overflow", overflow, 0);
        check("reset_busy", busy, 0);
        @(posedge clk); #1 rstn = 1'b1;
        repeat (2) @(posedge clk);

        // Latency from strobe to first valid byte
        alt_keypad = 1'b0;
        m_tready = 1'b1;
        push_seq(1, 8'h41, 8'h00, 8'h00);
        @(posedge clk); #1;
        key_code = 8'h41;
        key_strobe = 1'b1;
        lat = -1;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (m_tvalid && lat < 0) lat = i;
            if (i == SYNC + 2) key_strobe = 1'b0;
        end
        check("latency", lat, SYNC + 3);
        wait_idle("latency_idle", 100);
        check("latency_busy_clear", busy, 0);

        // Table of single-key mappings
        for (int v = 0; v < 18; v++) begin
            alt_keypad = vecs[v].alt;
            push_seq(vecs[v].n, vecs[v].b0, vecs[v].b1, vecs[v].b2);
            $display("vector %0d: key %02h alt %0b -> %0d bytes", v, vecs[v].code, vecs[v].alt,
                     vecs[v].n);
            strobe(vecs[v].code);
            wait_idle("vector_idle", 100);
            check("vector_busy_clear", busy, 0);
            check("vector_drained", exp_q.size(), 0);
        end

        // Random stalls during ESC ? p
        alt_keypad = 1'b1;
        push_seq(3, 8'h1B, 8'h3F, 8'h70);
        fork
            strobe(8'h90);
            begin
                repeat (40) begin
                    @(posedge clk); #1 m_tready = 1'($urandom_range(0, 1));
                end
                m_tready = 1'b1;
            end
        join
        wait_idle("stall_idle", 200);
        check("stall_drained", exp_q.size(), 0);
        alt_keypad = 1'b0;

        // Identify requests while ESC B is mid-send and 0x61 is queued
        m_tready = 1'b0;
        push_seq(2, 8'h1B, 8'h42, 8'h00);
        push_seq(3, 8'h1B, 8'h2F, 8'h4B);
        push_seq(1, 8'h61, 8'h00, 8'h00);
        strobe(8'h81);
        wait_valid("ident_esc_valid", 50);
        strobe(8'h61);
        @(posedge clk); #1 m_tready = 1'b1;
        @(posedge clk); #1 m_tready = 1'b0;
        @(posedge clk); #1 ident_req = 1'b1;
        @(posedge clk); #1 ident_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 ident_req = 1'b1;
        @(posedge clk); #1 ident_req = 1'b0;
        repeat (3) @(posedge clk);
        #1 m_tready = 1'b1;
        wait_idle("ident_idle", 200);
        check("ident_drained", exp_q.size(), 0);

        // Overflow: one key held in the output stage, then ten strobes into the queue
        m_tready = 1'b0;
        push_seq(1, 8'h30, 8'h00, 8'h00);
        strobe(8'h30);
        wait_valid("overflow_first_valid", 50);
        ovf_count = 0;
        for (int i = 0; i < 10; i++) begin
            if (i < DEPTH) push_seq(1, 8'h41 + 8'(i), 8'h00, 8'h00);
            strobe(8'h41 + 8'(i));
        end
        repeat (5) @(posedge clk);
        check("overflow_pulses", ovf_count, 2);
        #1 m_tready = 1'b1;
        wait_idle("overflow_idle", 300);
        check("overflow_drained", exp_q.size(), 0);

        // Reset after the ESC byte of ESC B, with another key queued
        m_tready = 1'b0;
        push_seq(1, 8'h1B, 8'h00, 8'h00);
        strobe(8'h81);
        wait_valid("reset_esc_valid", 50);
        strobe(8'h62);
        @(posedge clk); #1 m_tready = 1'b1;
        @(posedge clk); #1 m_tready = 1'b0;
        @(posedge clk); #1 rstn = 1'b0;
        @(posedge clk); #1 rstn = 1'b1;
        @(negedge clk);
        check("midreset_tvalid", m_tvalid, 0);
        check("midreset_busy", busy, 0);
        check("midreset_tdata", m_tdata, 0);
        @(posedge clk); #1 m_tready = 1'b1;
        repeat (20) @(posedge clk);
        check("midreset_no_trailing", exp_q.size(), 0);

        // Unmapped code after reset produces nothing and busy clears
        strobe(8'hC0);
        wait_idle("unmapped_idle", 100);
        check("unmapped_busy_clear", busy, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
